// File: rtl/mvm_pkg.sv
// ---------------------------------------------------------------------------
// mvm_pkg
// Shared types and default constants for the multi-crossbar MVM control
// sequencer and its wait timer.
//   mvm_state_e : sequencer FSM states
//   mvm_mode_e  : operation requested with start (compute / program weights)
//   DEF_*       : default parameter values
//   wait_cnt_width() : settle-timer counter width, never below one bit
// ---------------------------------------------------------------------------
package mvm_pkg;

   localparam int DEF_N_SIZE     = 4;
   localparam int DEF_NUM_XBAR   = 4;
   localparam int DEF_NUM_SLICES = 16;
   localparam int DEF_WAIT_CYC   = 2;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      PROG,
      RD,
      CALC,
      WAIT,
      SUM,
      DONE
   } mvm_state_e;

   typedef enum logic {
      MVM_COMPUTE = 1'b0,
      MVM_PROGRAM = 1'b1
   } mvm_mode_e;

   // A zero-cycle settle still needs a legal one-bit counter.
   function automatic int wait_cnt_width(input int wait_cyc);
      return (wait_cyc > 0) ? $clog2(wait_cyc + 1) : 1;
   endfunction

endpackage

// File: rtl/mvm_wait_timer.sv
// ---------------------------------------------------------------------------
// mvm_wait_timer
// Loadable down-counter timing the crossbar settle phase.
//   clk, rst_n : core clock, asynchronous active-low reset
//   load       : load WAIT_CYC-1 (asserted while the sequencer is in CALC)
//   active     : sequencer is in WAIT; counter decrements each cycle
//   expired    : high on the last WAIT cycle
// ---------------------------------------------------------------------------
module mvm_wait_timer
   import mvm_pkg::*;
#(
   parameter int WAIT_CYC = DEF_WAIT_CYC
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic active,
   output logic expired
);

   localparam int             CNT_W    = wait_cnt_width(WAIT_CYC);
   localparam logic [CNT_W-1:0] LOAD_VAL = (WAIT_CYC > 0) ? CNT_W'(WAIT_CYC - 1) : '0;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (active && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expired = active && (cnt == '0);

endmodule

// File: rtl/mvm_ctrl_seq.sv
// ---------------------------------------------------------------------------
// mvm_ctrl_seq
// Multi-crossbar MVM control sequencer. Steps input bit-slices through
// fetch/read/compute/settle/accumulate, or streams weight-program slices.
// All-zero slices (per channel skip) are bypassed without computing.
//   clk, rst_n : core clock, asynchronous active-low reset
//   start      : op request, sampled in IDLE only
//   mode       : 0 compute, 1 program weights (latched with start)
//   xbar_mask  : participating channels (latched with start)
//   abort      : synchronous cancel, highest priority
//   skip       : per-channel "current slice all-zero", sampled in RD
//   counter    : current slice index
//   fetch, rd_en, waiting, prog_wt : phase strobes
//   calc, up_sum : per-channel compute / accumulate strobes
//   get_ready, done : completion pulses;  busy : not IDLE
// ---------------------------------------------------------------------------
module mvm_ctrl_seq
   import mvm_pkg::*;
#(
   parameter int N_SIZE     = DEF_N_SIZE,
   parameter int NUM_XBAR   = DEF_NUM_XBAR,
   parameter int NUM_SLICES = DEF_NUM_SLICES,
   parameter int WAIT_CYC   = DEF_WAIT_CYC
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                mode,
   input  logic [NUM_XBAR-1:0] xbar_mask,
   input  logic                abort,
   input  logic [NUM_XBAR-1:0] skip,
   output logic [N_SIZE-1:0]   counter,
   output logic                fetch,
   output logic                rd_en,
   output logic [NUM_XBAR-1:0] calc,
   output logic                waiting,
   output logic [NUM_XBAR-1:0] up_sum,
   output logic                prog_wt,
   output logic                get_ready,
   output logic                busy,
   output logic                done
);

   localparam logic [N_SIZE-1:0] LAST_SLICE = N_SIZE'(NUM_SLICES - 1);

   mvm_state_e          state, state_next;
   mvm_mode_e           mode_q;
   logic [NUM_XBAR-1:0] act_mask;
   logic [NUM_XBAR-1:0] skip_q;
   logic [N_SIZE-1:0]   counter_next;
   logic [NUM_XBAR-1:0] eff;
   logic                last_slice;
   logic                wait_expired;

   // Channels that actually compute the current slice.
   assign eff        = act_mask & ~skip_q;
   assign last_slice = (counter == LAST_SLICE);

   mvm_wait_timer #(
      .WAIT_CYC (WAIT_CYC)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (state == CALC),
      .active  (state == WAIT),
      .expired (wait_expired)
   );

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         counter  <= '0;
         mode_q   <= MVM_COMPUTE;
         act_mask <= '0;
         skip_q   <= '0;
      end else begin
         state   <= state_next;
         counter <= counter_next;
         if (state == IDLE && start) begin
            mode_q   <= mvm_mode_e'(mode);
            act_mask <= xbar_mask;
         end
         if (state == RD) begin
            skip_q <= skip;
         end
      end
   end

   // NOTE: both next-state values get a default first so no path through the
   // case leaves them unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next   = state;
      counter_next = counter;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (xbar_mask == '0) begin
                  state_next = DONE;
               end else begin
                  state_next   = FETCH;
                  counter_next = '0;
               end
            end
         end
         FETCH: begin
            counter_next = '0;
            state_next   = (mode_q == MVM_PROGRAM) ? PROG : RD;
         end
         PROG: begin
            if (last_slice) begin
               state_next = DONE;
            end else begin
               counter_next = counter + 1'b1;
            end
         end
         RD: begin
            // Decision uses the live skip; skip_q holds it for CALC/SUM.
            if ((act_mask & ~skip) == '0) begin
               if (last_slice) begin
                  state_next = DONE;
               end else begin
                  counter_next = counter + 1'b1;
               end
            end else begin
               state_next = CALC;
            end
         end
         CALC: begin
            state_next = (WAIT_CYC > 0) ? WAIT : SUM;
         end
         WAIT: begin
            if (wait_expired) begin
               state_next = SUM;
            end
         end
         SUM: begin
            if (last_slice) begin
               state_next = DONE;
            end else begin
               counter_next = counter + 1'b1;
               state_next   = RD;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      if (abort && state != IDLE) begin
         state_next   = IDLE;
         counter_next = '0;
      end
   end

   assign fetch     = (state == FETCH);
   assign rd_en     = (state == RD);
   assign calc      = (state == CALC) ? eff : '0;
   assign waiting   = (state == WAIT);
   assign up_sum    = (state == SUM) ? eff : '0;
   assign prog_wt   = (state == PROG);
   assign get_ready = (state == DONE);
   assign done      = (state == DONE);
   assign busy      = (state != IDLE);

endmodule
